max_q_select: RTL and testbench
===============================

# max_q_select

Sequential max-Q search stage that sits directly upstream of the Q-update datapath. On a start request it reads the Q-table row of the next maze state, one action per cycle, and returns the largest legal Q value (signed 32-bit fixed point, 16 fractional bits) plus its action index. The result feeds the update stage's `max_Q` input and the agent's greedy action choice. It owns no table storage: it drives a 1-cycle-latency read port on the shared Q-table.

## Interface
- `N_STATES`, default 37: number of maze states (Q-table rows).
- `N_ACTIONS`, default 4: actions per state (Q-table columns).
- `QW`, default 32: Q value width, two's complement, 16 fractional bits.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, **asynchronous, active-low**.
- `start`  in  1: request a search; sampled only in IDLE.
- `next_state`  in  6: row to search, captured on accepted start.
- `terminal`  in  1: next state is terminal, captured on accepted start.
- `action_mask`  in  N_ACTIONS: 1 marks a legal move, captured on accepted start.
- `rd_en`  out  1: Q-table read strobe.
- `rd_state`  out  6: Q-table read row.
- `rd_action`  out  3: Q-table read column.
- `rd_data`  in  QW: Q-table data, valid the cycle after `rd_en`.
- `busy`  out  1: high from start acceptance until `done`, inclusive.
- `done`  out  1: one-cycle pulse when results are valid.
- `max_q`  out  QW: maximum legal Q value, held until the next accepted start.
- `best_action`  out  3: index of `max_q`, held.
- `no_valid`  out  1: no legal action or out-of-range state, held.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE, `start`=1:
  - Capture the inputs.
  - If `terminal`=1 or `next_state`>=N_STATES, go to FINISH with `max_q`=0, `best_action`=0. `no_valid` is 1 for an out-of-range state and 0 for a terminal state.
  - Otherwise go to ISSUE, with running max invalid and action counter 0.
- ISSUE: assert `rd_en` with `rd_state`=captured state and `rd_action`=counter, then increment the counter. After action N_ACTIONS-1 is issued, go to DRAIN. All actions are read regardless of mask, so the schedule is fixed.
- Compare pipeline: each returning `rd_data` is tagged with its delayed action index. If that action is masked in, compare it signed against the running max. It replaces the running max if the running max is invalid or the new value is strictly greater.
- DRAIN: consume the final datum, then go to FINISH.
- FINISH:
  - Register `max_q` and `best_action` from the running max.
  - If the running max is still invalid, output 0/0 and `no_valid`=1.
  - Pulse `done`, then return to IDLE.
- `start` while not IDLE is ignored, not queued.
- Outputs change only in FINISH and hold through IDLE.

## Timing
- Reset values: FSM IDLE, `rd_en`=0, `rd_state`=0, `rd_action`=0, `busy`=0, `done`=0, `max_q`=0, `best_action`=0, `no_valid`=0.
- Start accepted at edge T (N_ACTIONS=4):
  - `rd_en` high in cycles T+1..T+4, action 0..3.
  - Data arrives T+2..T+5.
  - `done` is high in cycle T+6.
  - Latency is N_ACTIONS+2 cycles.
- Terminal or out-of-range start: `done` in cycle T+2, no `rd_en`.
- `busy` is high T+1 through the `done` cycle.
- Back-to-back: a new start is accepted in the cycle after `done`.
- Reset mid-search: immediate return to IDLE, all outputs to reset values, `rd_en` drops asynchronously, no `done`.

## Configuration
- `MAXQ_LFSR_TIEBREAK_EN` defined: a 16-bit Galois LFSR (poly x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every cycle. On an equal legal value, the new action replaces the incumbent when LFSR bit 0 is 1.
- Undefined: ties keep the lowest action index, and no LFSR is instantiated.

## Structure
- Shared package `q_learn_pkg`:
  - N_STATES, N_ACTIONS, QW, FRAC_BITS=16.
  - `q_t` (signed QW), `state_t` (6 bit), `action_t` (3 bit).
  - FSM enum.
- The update stage imports the same package.
- Sub-module `lfsr16`, instantiated only under `MAXQ_LFSR_TIEBREAK_EN`.

## Test plan
- State 5, mask 4'b1111, row {0x00010000, 0xFFFF0000, 0x00030000, 0x00020000} → `done` at T+6, `max_q`=0x00030000, `best_action`=2, `no_valid`=0.
- All-negative row {-3.0, -1.0, -2.0, -4.0}, mask 4'b1111 → `max_q`=0xFFFF0000 (-1.0), `best_action`=1. Confirms the compare is signed.
- Mask 4'b1011 with action 2 holding the row maximum → the maximum among actions 0, 1, 3 is selected. Mask 4'b0000 → `max_q`=0, `no_valid`=1.
- `terminal`=1 → `done` at T+2, `max_q`=0, no `rd_en`. `next_state`=40 → `no_valid`=1, no `rd_en`.
- Row of equal values 0x00050000 → macro undefined: `best_action`=0 every run. Macro defined: `best_action` varies over runs and matches a reference LFSR model.
- `rst` low at T+3, `start` ignored while busy → outputs at reset values, no `done`. The next search runs normally with the correct latency.

Source files
------------

// File: rtl/q_learn_pkg.sv
// Shared Q-learning types and constants, imported by the max-Q search and the update stage.
package q_learn_pkg;

  localparam int N_STATES  = 37;
  localparam int N_ACTIONS = 4;
  localparam int QW        = 32;
  localparam int FRAC_BITS = 16;

  typedef logic signed [QW-1:0] q_t;
  typedef logic [5:0]           state_t;
  typedef logic [2:0]           action_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } fsm_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/max_q_select_lfsr16.sv
// Free-running 16-bit Galois LFSR used to randomise max-Q tie breaks.
// Only built when MAXQ_LFSR_TIEBREAK_EN is defined.
`ifdef MAXQ_LFSR_TIEBREAK_EN
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] o_lfsr
);
  import q_learn_pkg::*;

  logic [15:0] r_lfsr;

  // advance once per cycle from the fixed seed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr16_step(r_lfsr);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule
`endif

// File: rtl/max_q_select.sv
// Sequential max-Q search over one Q-table row through a 1-cycle-latency read port.
// Optional macro MAXQ_LFSR_TIEBREAK_EN: LFSR-driven replacement on equal legal values.
module max_q_select #(
  parameter int N_STATES  = q_learn_pkg::N_STATES,
  parameter int N_ACTIONS = q_learn_pkg::N_ACTIONS,
  parameter int QW        = q_learn_pkg::QW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [5:0]           next_state,
  input  logic                 terminal,
  input  logic [N_ACTIONS-1:0] action_mask,
  output logic                 rd_en,
  output logic [5:0]           rd_state,
  output logic [2:0]           rd_action,
  input  logic [QW-1:0]        rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [QW-1:0]        max_q,
  output logic [2:0]           best_action,
  output logic                 no_valid
);
  import q_learn_pkg::*;

  localparam action_t A_LAST = 3'(N_ACTIONS - 1);

  fsm_t                  r_state;
  fsm_t                  w_state_nxt;
  logic                  r_rd_en;
  state_t                r_rd_state;
  action_t               r_rd_action;
  action_t               r_cnt;
  logic [N_ACTIONS-1:0]  r_mask;
  logic                  r_term;
  logic                  r_oor;
  logic                  r_tag_valid;
  action_t               r_tag_action;
  logic                  r_run_valid;
  logic signed [QW-1:0]  r_run_max;
  action_t               r_run_action;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_no_valid;
  logic [QW-1:0]         r_max_q;
  action_t               r_best;

  logic                  w_accept;
  logic                  w_oor_in;
  logic                  w_rd_en_nxt;
  action_t               w_rd_action_nxt;
  action_t               w_cnt_nxt;
  logic                  w_fin;
  logic                  w_mask_bit;
  logic                  w_gt;
  logic                  w_eq;
  logic                  w_tie_take;
  logic                  w_take;
  logic                  w_cand_valid;
  logic signed [QW-1:0]  w_cand_max;
  action_t               w_cand_action;

`ifdef MAXQ_LFSR_TIEBREAK_EN
  logic [15:0] w_lfsr;

  lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .o_lfsr (w_lfsr)
  );
`endif

  // no new search while the done pulse is still on the wire
  assign w_accept = (r_state == ST_IDLE) && start && !r_done;
  assign w_oor_in = int'(next_state) >= N_STATES;

  // next-state and read-port schedule; rd_* are registered one step ahead of use
  always_comb begin
    w_state_nxt     = r_state;
    w_rd_en_nxt     = 1'b0;
    w_rd_action_nxt = r_rd_action;
    w_cnt_nxt       = r_cnt;
    w_fin           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (terminal || w_oor_in) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_rd_en_nxt     = 1'b1;
            w_rd_action_nxt = 3'd0;
            w_cnt_nxt       = 3'd1;
            w_state_nxt     = (N_ACTIONS == 1) ? ST_DRAIN : ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_rd_en_nxt     = 1'b1;
        w_rd_action_nxt = r_cnt;
        w_cnt_nxt       = r_cnt + 3'd1;
        if (r_cnt == A_LAST) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        w_fin       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // legality of the returning datum, selected by its delayed action tag
  always_comb begin
    w_mask_bit = 1'b0;
    for (int i = 0; i < N_ACTIONS; i++) begin
      w_mask_bit = w_mask_bit | ((r_tag_action == 3'(i)) & r_mask[i]);
    end
  end

  // signed compare against the running max; the final datum is folded in during FINISH
  always_comb begin
    w_gt = $signed(rd_data) > r_run_max;
    w_eq = $signed(rd_data) == r_run_max;
`ifdef MAXQ_LFSR_TIEBREAK_EN
    w_tie_take = w_lfsr[0];
`else
    w_tie_take = 1'b0;
`endif
    w_take        = r_tag_valid && w_mask_bit && (!r_run_valid || w_gt || (w_eq && w_tie_take));
    w_cand_valid  = r_run_valid | w_take;
    w_cand_max    = w_take ? $signed(rd_data) : r_run_max;
    w_cand_action = w_take ? r_tag_action : r_run_action;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // read port, captured request and compare-pipeline tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_en      <= 1'b0;
      r_rd_state   <= 6'd0;
      r_rd_action  <= 3'd0;
      r_cnt        <= 3'd0;
      r_mask       <= '0;
      r_term       <= 1'b0;
      r_oor        <= 1'b0;
      r_tag_valid  <= 1'b0;
      r_tag_action <= 3'd0;
    end else begin
      r_rd_en      <= w_rd_en_nxt;
      r_rd_action  <= w_rd_action_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tag_valid  <= r_rd_en;
      r_tag_action <= r_rd_action;
      if (w_accept) begin
        r_rd_state <= next_state;
        r_mask     <= action_mask;
        r_term     <= terminal;
        r_oor      <= w_oor_in;
      end
    end
  end

  // running maximum, invalidated on every accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run_valid  <= 1'b0;
      r_run_max    <= '0;
      r_run_action <= 3'd0;
    end else if (w_accept) begin
      r_run_valid  <= 1'b0;
      r_run_max    <= '0;
      r_run_action <= 3'd0;
    end else if (w_take) begin
      r_run_valid  <= 1'b1;
      r_run_max    <= $signed(rd_data);
      r_run_action <= r_tag_action;
    end
  end

  // result registers change only when leaving FINISH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_max_q    <= '0;
      r_best     <= 3'd0;
      r_no_valid <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE) || w_fin;
      r_done <= w_fin;
      if (w_fin) begin
        if (r_term || r_oor) begin
          r_max_q    <= '0;
          r_best     <= 3'd0;
          r_no_valid <= r_oor;
        end else if (!w_cand_valid) begin
          r_max_q    <= '0;
          r_best     <= 3'd0;
          r_no_valid <= 1'b1;
        end else begin
          r_max_q    <= w_cand_max;
          r_best     <= w_cand_action;
          r_no_valid <= 1'b0;
        end
      end
    end
  end

  assign rd_en       = r_rd_en;
  assign rd_state    = r_rd_state;
  assign rd_action   = r_rd_action;
  assign busy        = r_busy;
  assign done        = r_done;
  assign max_q       = r_max_q;
  assign best_action = r_best;
  assign no_valid    = r_no_valid;

endmodule

// File: tb/tb_max_q_select.sv
// Directed self-checking bench for max_q_select with a behavioural Q-table read port.
`timescale 1ns/1ps
module tb_max_q_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  next_state;
  logic        terminal;
  logic [3:0]  action_mask;
  logic        rd_en;
  logic [5:0]  rd_state;
  logic [2:0]  rd_action;
  logic [31:0] rd_data = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] max_q;
  logic [2:0]  best_action;
  logic        no_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] qmem [0:63][0:3];
  logic [15:0] m_lfsr;

  logic        obs_rd_en  [1:10];
  logic [2:0]  obs_rd_act [1:10];
  logic [5:0]  obs_rd_st  [1:10];
  logic        obs_done   [1:10];
  logic        obs_busy   [1:10];
  logic        obs_l0     [1:10];

  max_q_select #(.N_STATES(37), .N_ACTIONS(4), .QW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .next_state  (next_state),
    .terminal    (terminal),
    .action_mask (action_mask),
    .rd_en       (rd_en),
    .rd_state    (rd_state),
    .rd_action   (rd_action),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .max_q       (max_q),
    .best_action (best_action),
    .no_valid    (no_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= qmem[rd_state][rd_action[1:0]];
  end

  // reference tie-break LFSR: x^16+x^14+x^13+x^11+1, seed ACE1
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  // Drives one start, then records ncyc cycles (cycle 1 = first cycle after the accepting edge).
  // At cycle poke_cyc a conflicting start is presented to check it is ignored.
  task automatic run_search(input logic [5:0] st, input logic term, input logic [3:0] mask,
                            input int ncyc, input int poke_cyc);
    for (int k = 1; k <= 10; k++) begin
      obs_rd_en[k] = 1'b0; obs_rd_act[k] = 3'd0; obs_rd_st[k] = 6'd0;
      obs_done[k] = 1'b0; obs_busy[k] = 1'b0; obs_l0[k] = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b1; next_state = st; terminal = term; action_mask = mask;
    @(posedge clk); #1;
    start = 1'b0; next_state = 6'd0; terminal = 1'b0; action_mask = 4'b0000;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      obs_rd_en[k] = rd_en; obs_rd_act[k] = rd_action; obs_rd_st[k] = rd_state;
      obs_done[k] = done; obs_busy[k] = busy; obs_l0[k] = m_lfsr[0];
      if (k == poke_cyc) begin
        start = 1'b1; next_state = 6'd40; terminal = 1'b1; action_mask = 4'b1111;
      end else begin
        start = 1'b0; next_state = 6'd0; terminal = 1'b0; action_mask = 4'b0000;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_en, rd_state, rd_action, busy, done, max_q, best_action, no_valid} !== 46'd0) begin
      errors++;
      $display("FAIL reset_vals got rd_en=%b st=%0d act=%0d busy=%b done=%b max_q=%h best=%0d nv=%b required all zero",
               rd_en, rd_state, rd_action, busy, done, max_q, best_action, no_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_en, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset_idle got rd_en=%b busy=%b done=%b required 000", rd_en, busy, done);
    end
  endtask

  task automatic test_basic;
    run_search(6'd5, 1'b0, 4'b1111, 8, 0);
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (obs_rd_en[k] !== (k <= 4) || obs_done[k] !== (k == 6) || obs_busy[k] !== (k <= 6) ||
          (k <= 4 && (obs_rd_act[k] !== 3'(k - 1) || obs_rd_st[k] !== 6'd5))) begin
        errors++;
        $display("FAIL basic_sched cyc%0d got rd_en=%b act=%0d st=%0d done=%b busy=%b required rd_en=%b act=%0d st=5 done=%b busy=%b",
                 k, obs_rd_en[k], obs_rd_act[k], obs_rd_st[k], obs_done[k], obs_busy[k], k <= 4, k - 1, k == 6, k <= 6);
      end
    end
    checks++;
    if (max_q !== 32'h00030000 || best_action !== 3'd2 || no_valid !== 1'b0) begin
      errors++; $display("FAIL basic_result got %h/%0d/%b required 00030000/2/0", max_q, best_action, no_valid);
    end
  endtask

  task automatic test_signed;
    logic [5:0]  st_t [0:2];
    logic [3:0]  mk_t [0:2];
    logic [31:0] mq_t [0:2];
    logic [2:0]  ba_t [0:2];
    st_t = '{6'd7, 6'd7, 6'd8};
    mk_t = '{4'b1111, 4'b1100, 4'b1111};
    mq_t = '{32'hFFFF0000, 32'hFFFE0000, 32'h7FFFFFFF};
    ba_t = '{3'd1, 3'd2, 3'd3};
    for (int i = 0; i < 3; i++) begin
      run_search(st_t[i], 1'b0, mk_t[i], 7, 0);
      checks++;
      if (max_q !== mq_t[i] || best_action !== ba_t[i] || no_valid !== 1'b0 || obs_done[6] !== 1'b1) begin
        errors++;
        $display("FAIL signed_%0d got %h/%0d/%b done6=%b required %h/%0d/0 done6=1",
                 i, max_q, best_action, no_valid, obs_done[6], mq_t[i], ba_t[i]);
      end
    end
  endtask

  task automatic test_mask;
    logic [3:0]  mk_t [0:2];
    logic [31:0] mq_t [0:2];
    logic [2:0]  ba_t [0:2];
    logic        nv_t [0:2];
    mk_t = '{4'b1011, 4'b0000, 4'b0011};
    mq_t = '{32'h00030000, 32'h00000000, 32'h00020000};
    ba_t = '{3'd3, 3'd0, 3'd1};
    nv_t = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_search(6'd9, 1'b0, mk_t[i], 7, 0);
      checks++;
      if (max_q !== mq_t[i] || best_action !== ba_t[i] || no_valid !== nv_t[i]) begin
        errors++;
        $display("FAIL mask_%b got %h/%0d/%b required %h/%0d/%b",
                 mk_t[i], max_q, best_action, no_valid, mq_t[i], ba_t[i], nv_t[i]);
      end
    end
  endtask

  task automatic test_range;
    logic [5:0]  st_t [0:4];
    logic        tm_t [0:4];
    logic [31:0] mq_t [0:4];
    logic [2:0]  ba_t [0:4];
    logic        nv_t [0:4];
    logic        nr_t [0:4];
    int          dc;
    int          nrd;
    st_t = '{6'd36, 6'd5, 6'd40, 6'd37, 6'd5};
    tm_t = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    mq_t = '{32'h00000020, 32'h0, 32'h0, 32'h0, 32'h0};
    ba_t = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    nv_t = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    nr_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_search(st_t[i], tm_t[i], 4'b1111, 8, 0);
      dc = 0; nrd = 0;
      for (int k = 8; k >= 1; k--) begin
        if (obs_done[k]) dc = k;
        if (obs_rd_en[k]) nrd++;
      end
      checks++;
      if (dc !== (nr_t[i] ? 2 : 6) || nrd !== (nr_t[i] ? 0 : 4) || obs_busy[dc + 1] !== 1'b0) begin
        errors++;
        $display("FAIL range_st%0d_t%b got done_cyc=%0d rd_cnt=%0d required done_cyc=%0d rd_cnt=%0d",
                 st_t[i], tm_t[i], dc, nrd, nr_t[i] ? 2 : 6, nr_t[i] ? 0 : 4);
      end
      checks++;
      if (max_q !== mq_t[i] || best_action !== ba_t[i] || no_valid !== nv_t[i]) begin
        errors++;
        $display("FAIL range_res_st%0d_t%b got %h/%0d/%b required %h/%0d/%b",
                 st_t[i], tm_t[i], max_q, best_action, no_valid, mq_t[i], ba_t[i], nv_t[i]);
      end
    end
  endtask

  task automatic test_ties;
    logic [2:0] eb;
    for (int r = 0; r < 3; r++) begin
      run_search(6'd11, 1'b0, 4'b1111, 7, 0);
      eb = 3'd0;
`ifdef MAXQ_LFSR_TIEBREAK_EN
      // data for action a is compared in cycle a+2
      for (int a = 1; a < 4; a++) begin
        if (obs_l0[a + 2]) eb = 3'(a);
      end
`endif
      checks++;
      if (max_q !== 32'h00050000 || best_action !== eb || no_valid !== 1'b0) begin
        errors++;
        $display("FAIL ties_run%0d got %h/%0d/%b required 00050000/%0d/0", r, max_q, best_action, no_valid, eb);
      end
    end
  endtask

  task automatic test_busy_ignore;
    run_search(6'd5, 1'b0, 4'b1111, 9, 2);
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (obs_rd_en[k] !== (k <= 4) || obs_done[k] !== (k == 6) || (k <= 4 && obs_rd_st[k] !== 6'd5)) begin
        errors++;
        $display("FAIL ignore_sched cyc%0d got rd_en=%b st=%0d done=%b required rd_en=%b st=5 done=%b",
                 k, obs_rd_en[k], obs_rd_st[k], obs_done[k], k <= 4, k == 6);
      end
    end
    checks++;
    if (max_q !== 32'h00030000 || best_action !== 3'd2 || no_valid !== 1'b0) begin
      errors++; $display("FAIL ignore_result got %h/%0d/%b required 00030000/2/0", max_q, best_action, no_valid);
    end
  endtask

  task automatic test_reset_mid;
    int dc;
    @(posedge clk); #1;
    start = 1'b1; next_state = 6'd8; action_mask = 4'b1111;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rd_en !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got rd_en=%b busy=%b required 1 1", rd_en, busy);
    end
    rst = 1'b0; start = 1'b1;
    #1;
    checks++;
    if ({rd_en, rd_state, rd_action, busy, done, max_q, best_action, no_valid} !== 46'd0) begin
      errors++;
      $display("FAIL rstmid_vals got rd_en=%b st=%0d act=%0d busy=%b done=%b max_q=%h best=%0d nv=%b required all zero",
               rd_en, rd_state, rd_action, busy, done, max_q, best_action, no_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
        errors++; $display("FAIL rstmid_hold cyc%0d got done=%b busy=%b rd_en=%b required 0 0 0", k, done, busy, rd_en);
      end
    end
    start = 1'b0; rst = 1'b1;
    run_search(6'd5, 1'b0, 4'b1111, 8, 0);
    dc = 0;
    for (int k = 8; k >= 1; k--) if (obs_done[k]) dc = k;
    checks++;
    if (dc !== 6 || obs_rd_en[1] !== 1'b1 || obs_rd_en[5] !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got done_cyc=%0d rd1=%b rd5=%b required 6 1 0", dc, obs_rd_en[1], obs_rd_en[5]);
    end
    checks++;
    if (max_q !== 32'h00030000 || best_action !== 3'd2 || no_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_result got %h/%0d/%b required 00030000/2/0", max_q, best_action, no_valid);
    end
  endtask

  task automatic test_back_to_back;
    run_search(6'd9, 1'b0, 4'b0100, 6, 0);
    checks++;
    if (obs_done[6] !== 1'b1 || max_q !== 32'h00090000 || best_action !== 3'd2) begin
      errors++; $display("FAIL b2b_first got done=%b %h/%0d required 1 00090000/2", obs_done[6], max_q, best_action);
    end
    run_search(6'd7, 1'b0, 4'b1111, 7, 0);
    checks++;
    if (obs_busy[1] !== 1'b1 || obs_rd_en[1] !== 1'b1 || obs_done[5] !== 1'b0 || obs_done[6] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_sched got busy1=%b rd1=%b done5=%b done6=%b required 1 1 0 1",
               obs_busy[1], obs_rd_en[1], obs_done[5], obs_done[6]);
    end
    checks++;
    if (max_q !== 32'hFFFF0000 || best_action !== 3'd1 || no_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_second got %h/%0d/%b required FFFF0000/1/0", max_q, best_action, no_valid);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; next_state = 6'd0; terminal = 1'b0; action_mask = 4'b0000;
    for (int s = 0; s < 64; s++) begin
      for (int a = 0; a < 4; a++) qmem[s][a] = 32'd0;
    end
    qmem[5]  = '{32'h00010000, 32'hFFFF0000, 32'h00030000, 32'h00020000};
    qmem[7]  = '{32'hFFFD0000, 32'hFFFF0000, 32'hFFFE0000, 32'hFFFC0000};
    qmem[8]  = '{32'h00010000, 32'hFFFF0000, 32'h80000000, 32'h7FFFFFFF};
    qmem[9]  = '{32'h00010000, 32'h00020000, 32'h00090000, 32'h00030000};
    qmem[11] = '{32'h00050000, 32'h00050000, 32'h00050000, 32'h00050000};
    qmem[36] = '{32'h00000010, 32'h00000020, 32'h00000005, 32'h00000001};
    test_reset;
    test_basic;
    test_signed;
    test_mask;
    test_range;
    test_ties;
    test_busy_ignore;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary within 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
